jk_updown_counter: RTL and testbench

//   Synchronous modulo-N up/down counter. Every state bit is a JK flip-flop cell.
//   A combinational steering stage drives the J/K inputs of the cells.
//   It is the consumer stage for the JK flip-flop primitive: it turns a bank of
//   JK cells into a loadable counter with terminal-count and overflow outputs.

---
 rtl/jk_counter_pkg.sv | 29 ++
 rtl/jk_cell.sv | 34 +++
 rtl/jk_updown_counter.sv | 104 ++++++++++
 tb/tb_jk_updown_counter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/jk_counter_pkg.sv
// jk_counter_pkg
//   Shared definitions for the JK-based counter library.
//   - jk_cmd_t : the four {j,k} command encodings a JK cell understands
//   - jk_for   : smallest {j,k} command that moves a cell from cur to nxt
package jk_counter_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_cmd_t;

  // HOLD when no change is wanted, SET for 0->1 and RST for 1->0.
  // TGL is never the minimal choice because SET/RST already cover
  // every real transition without depending on the current value.
  function automatic jk_cmd_t jk_for(input logic cur, input logic nxt);
    jk_cmd_t cmd;
    if (cur == nxt) begin
      cmd = JK_HOLD;
    end else if (nxt) begin
      cmd = JK_SET;
    end else begin
      cmd = JK_RST;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// jk_cell
//   A single JK flip-flop with asynchronous active-low reset to 0.
//   Ports:
//     j, k : command inputs (see jk_cmd_t)
//     clk  : rising-edge clock
//     rst  : asynchronous reset, active-low
//     q    : stored bit
module jk_cell
  import jk_counter_pkg::*;
(
  input  logic j,
  input  logic k,
  input  logic clk,
  input  logic rst,
  output logic q
);

  // Classic JK behaviour expressed through the shared command encodings:
  // hold, force 0, force 1 or invert. Reset wins over everything and does
  // not wait for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else begin
      unique case ({j, k})
        JK_HOLD: q <= q;
        JK_RST:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TGL:  q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_updown_counter.sv
// jk_updown_counter
//   Loadable modulo-MODULO up/down counter built from a bank of JK cells.
//   A combinational steering stage computes every cell's J/K so the bank
//   as a whole counts, wraps, holds or loads.
//   Parameters:
//     WIDTH  : counter width in bits
//     MODULO : count range 0..MODULO-1 (2 <= MODULO <= 2**WIDTH)
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous reset, active-low
//     en   : count enable
//     up   : 1 = increment, 0 = decrement
//     load : synchronous parallel load, beats en
//     din  : value to load
//     q    : current count
//     tc   : next edge will wrap (combinational)
//     ovf  : one-cycle pulse following each wrap edge
module jk_updown_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             atTop;
  logic             atZero;

  // Values loaded above TOP are left alone, so the top compare is >= rather
  // than ==; this sends any out-of-range value straight to 0 when counting up.
  assign atTop  = (q >= TOP);
  assign atZero = (q == '0);

  assign tc = ~load & en & ((up & atTop) | (~up & atZero));

  // Steering stage. Priority is load, hold, up-wrap, down-wrap, then the
  // normal ripple-free toggle chains. carry tracks "all lower bits are 1"
  // and borrow tracks "all lower bits are 0" as the loop walks upward, so
  // bit 0 always sees both chains asserted and always toggles.
  always_comb begin
    logic carry;
    logic borrow;
    j      = '0;
    k      = '0;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (load) begin
        j[i] = din[i];
        k[i] = ~din[i];
      end else if (!en) begin
        {j[i], k[i]} = JK_HOLD;
      end else if (up && atTop) begin
        {j[i], k[i]} = JK_RST;
      end else if (!up && atZero) begin
        j[i] = TOP[i];
        k[i] = ~TOP[i];
      end else if (up) begin
        j[i] = carry;
        k[i] = carry;
      end else begin
        j[i] = borrow;
        k[i] = borrow;
      end
      carry  = carry & q[i];
      borrow = borrow & ~q[i];
    end
  end

  // One JK cell per count bit; the cells' outputs are the count itself.
  for (genvar g = 0; g < WIDTH; g++) begin : gen_cells
    jk_cell u_cell (
      .j  (j[g]),
      .k  (k[g]),
      .clk(clk),
      .rst(rst),
      .q  (q[g])
    );
  end

  // ovf is just tc delayed by one edge, which makes it high exactly in the
  // cycle after a wrap. It clears asynchronously together with the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else begin
      ovf <= tc;
    end
  end

endmodule

// File: tb/tb_jk_updown_counter.sv
// tb_jk_updown_counter
//   Scoreboard bench for jk_updown_counter. Two instances share clk, rst,
//   up and din: dutA uses WIDTH=4/MODULO=10, dutB uses the defaults.
//   Each stimulus step pushes the expected q/tc/ovf for that cycle; a
//   monitor pops and compares at every falling edge.
module tb_jk_updown_counter;

  typedef struct {
    bit         sel;
    logic [3:0] q;
    logic       tc;
    logic       ovf;
    string      name;
  } expect_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       up = 1'b0;
  logic [3:0] din = '0;
  logic       enA = 1'b0;
  logic       loadA = 1'b0;
  logic       enB = 1'b0;
  logic       loadB = 1'b0;
  logic [3:0] qA;
  logic [3:0] qB;
  logic       tcA;
  logic       tcB;
  logic       ovfA;
  logic       ovfB;

  expect_t    sb[$];
  int         checks = 0;
  int         errors = 0;

  jk_updown_counter #(.WIDTH(4), .MODULO(10)) dutA (
    .clk (clk),
    .rst (rst),
    .en  (enA),
    .up  (up),
    .load(loadA),
    .din (din),
    .q   (qA),
    .tc  (tcA),
    .ovf (ovfA)
  );

  jk_updown_counter dutB (
    .clk (clk),
    .rst (rst),
    .en  (enB),
    .up  (up),
    .load(loadB),
    .din (din),
    .q   (qB),
    .tc  (tcB),
    .ovf (ovfB)
  );

  always #5 clk = ~clk;

  // Compares one scoreboard entry against whichever instance it targets.
  task automatic checkOutput(input expect_t e);
    logic [3:0] aq;
    logic       atc;
    logic       aovf;
    aq   = e.sel ? qB : qA;
    atc  = e.sel ? tcB : tcA;
    aovf = e.sel ? ovfB : ovfA;
    checks++;
    if (aq !== e.q || atc !== e.tc || aovf !== e.ovf) begin
      errors++;
      $display("[TB] FAIL %s: got q=%0d tc=%b ovf=%b, expected q=%0d tc=%b ovf=%b",
               e.name, aq, atc, aovf, e.q, e.tc, e.ovf);
    end
  endtask

  // Monitor: the counter presents a new state every cycle, so any queued
  // expectation is due at the next falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      checkOutput(sb.pop_front());
    end
  end

  // Drives one cycle's inputs just after the rising edge and records what
  // the targeted instance should show for the rest of that cycle.
  task automatic applyStimulus(input bit sel, input bit rstV, input bit enV,
                               input bit upV, input bit loadV,
                               input logic [3:0] dinV, input logic [3:0] eq,
                               input bit etc, input bit eovf, input string nm);
    expect_t e;
    @(posedge clk);
    #1;
    rst   = rstV;
    up    = upV;
    din   = dinV;
    enA   = sel ? 1'b0 : enV;
    loadA = sel ? 1'b0 : loadV;
    enB   = sel ? enV : 1'b0;
    loadB = sel ? loadV : 1'b0;
    e.sel  = sel;
    e.q    = eq;
    e.tc   = etc;
    e.ovf  = eovf;
    e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    logic [3:0] eq;
    int         waitCycles;

    // Power-up reset
    applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, "reset_state_A");
    applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, "reset_state_B");

    // Up count with wrap at 9 (release reset on the first step)
    for (int n = 0; n < 12; n++) begin
      eq = 4'(n % 10);
      applyStimulus(0, 1, 1, 1, 0, 4'd0, eq, eq == 4'd9, n == 10,
                    $sformatf("up_wrap_%0d", n));
    end

    // Down wrap from 0 to 9
    applyStimulus(0, 1, 1, 0, 1, 4'd0,  4'd2,  0, 0, "load0_with_en");
    applyStimulus(0, 1, 1, 0, 0, 4'd0,  4'd0,  1, 0, "down_tc_at_0");
    applyStimulus(0, 1, 1, 0, 0, 4'd0,  4'd9,  0, 1, "down_wrap_to_9");
    applyStimulus(0, 1, 1, 0, 0, 4'd0,  4'd8,  0, 0, "down_8");
    applyStimulus(0, 1, 1, 0, 0, 4'd0,  4'd7,  0, 0, "down_7");

    // Out-of-range load, then up wrap and down decrement from it
    applyStimulus(0, 1, 1, 1, 1, 4'hC,  4'd6,  0, 0, "loadC_en_up");
    applyStimulus(0, 1, 1, 1, 0, 4'd0,  4'd12, 1, 0, "oor_up_tc");
    applyStimulus(0, 1, 1, 1, 0, 4'd0,  4'd0,  0, 1, "oor_up_wrap");
    applyStimulus(0, 1, 0, 1, 1, 4'hC,  4'd1,  0, 0, "loadC_hold");
    applyStimulus(0, 1, 1, 0, 0, 4'd0,  4'd12, 0, 0, "oor_down_no_tc");
    applyStimulus(0, 1, 0, 0, 0, 4'd0,  4'd11, 0, 0, "oor_down_dec");

    // Hold at 7 with direction toggling, then count down
    applyStimulus(0, 1, 0, 1, 1, 4'd7,  4'd11, 0, 0, "load7");
    applyStimulus(0, 1, 0, 1, 0, 4'd0,  4'd7,  0, 0, "hold7_up");
    applyStimulus(0, 1, 0, 0, 0, 4'd0,  4'd7,  0, 0, "hold7_down");
    applyStimulus(0, 1, 0, 1, 0, 4'd0,  4'd7,  0, 0, "hold7_up2");
    applyStimulus(0, 1, 1, 0, 0, 4'd0,  4'd7,  0, 0, "count_down_from7");
    applyStimulus(0, 1, 1, 1, 0, 4'd0,  4'd6,  0, 0, "dir_change_up");
    applyStimulus(0, 1, 0, 1, 0, 4'd0,  4'd7,  0, 0, "dir_change_result");

    // Load at the top with en=1 suppresses the wrap
    applyStimulus(0, 1, 0, 1, 1, 4'd9,  4'd7,  0, 0, "load9");
    applyStimulus(0, 1, 1, 1, 1, 4'd3,  4'd9,  0, 0, "load_beats_wrap");
    applyStimulus(0, 1, 0, 1, 0, 4'd0,  4'd3,  0, 0, "no_ovf_after_load");

    // Asynchronous reset mid-cycle from q=5
    applyStimulus(0, 1, 0, 1, 1, 4'd5,  4'd3,  0, 0, "load5");
    applyStimulus(0, 1, 0, 1, 0, 4'd0,  4'd5,  0, 0, "hold5");
    applyStimulus(0, 0, 0, 1, 0, 4'd0,  4'd0,  0, 0, "async_reset");
    applyStimulus(0, 0, 1, 1, 0, 4'd0,  4'd0,  0, 0, "reset_held_en");
    applyStimulus(0, 1, 0, 1, 0, 4'd0,  4'd0,  0, 0, "reset_release");

    // Default parameters: 21 up steps through the 15->0 roll-over
    for (int n = 0; n < 21; n++) begin
      eq = 4'(n % 16);
      applyStimulus(1, 1, 1, 1, 0, 4'd0, eq, eq == 4'd15, n == 16,
                    $sformatf("bin_up_%0d", n));
    end

    waitCycles = 0;
    while (sb.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
